pipe_hazard_ctrl: RTL

- Parametrised pipeline stall/flush controller for the in-order RISC-V core, generalising the fixed 5-stage stall priority logic.
- Accepts per-stage stall requests and flush requests. Produces freeze masks, bubble-insert masks and flush masks for the stage registers.
- Holds a pending flush while its source stage is frozen.
- Keeps saturating performance counters and a sticky stall watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stall / flush controller for the in-order pipeline. Turns per-stage stall
// requests into a thermometer freeze mask plus bubble-insert mask, and turns
// flush requests into invalidate masks for the younger stage registers. A
// flush whose source stage is frozen is parked until that stage moves again.
// Also keeps saturating performance counters and a sticky stall watchdog.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active-low
//   stall_req      per-stage stall requests (bit 0 = PC stage)
//   flush_req      flush request
//   flush_stage    stage index of the flush source (1..STAGES-1)
//   perf_clr       synchronous clear of both performance counters
//   stall_out      per-stage hold enables
//   bubble_out     per-stage NOP-insert enables
//   flush_out      per-stage invalidate enables
//   flush_pending  a flush is parked waiting for its source to unfreeze
//   wdog_timeout   sticky "stalled too long" flag
//   stall_cycles   saturating count of stalled cycles
//   flush_count    saturating count of issued flushes
//
// Flush FSM
//   state        | meaning
//   ST_IDLE      | nothing parked, no flush mask being held
//   ST_PEND      | flush parked, its source stage is frozen
//   ST_HOLD      | issued flush mask still being driven (hold_cnt > 0)
//   ST_PEND_HOLD | both of the above at once
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int STAGES     = 5,
    parameter int SW         = 3,
    parameter int FLUSH_HOLD = 1,
    parameter int WDOG_LIMIT = 1023,
    parameter int WDOG_W     = 10,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              flush_req,
    input  logic [SW-1:0]     flush_stage,
    input  logic              perf_clr,
    output logic [STAGES-1:0] stall_out,
    output logic [STAGES-1:0] bubble_out,
    output logic [STAGES-1:0] flush_out,
    output logic              flush_pending,
    output logic              wdog_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // Hold counter only needs to reach FLUSH_HOLD-1; keep it at least 1 bit.
    localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HW-1:0]     HOLD_LOAD = HW'(FLUSH_HOLD - 1);
    localparam logic              HOLD_ON_ISSUE = (FLUSH_HOLD > 1);
    localparam logic [SW:0]       STAGES_W  = (SW+1)'(STAGES);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PEND      = 2'b01,
        ST_HOLD      = 2'b10,
        ST_PEND_HOLD = 2'b11
    } flush_state_t;

    flush_state_t      state, state_n;
    logic [SW-1:0]     pend_stage, pend_stage_n;
    logic [HW-1:0]     hold_cnt, hold_cnt_n;
    logic [STAGES-1:0] hold_mask, hold_mask_n;

    logic [STAGES-1:0] stall_mask;
    logic [STAGES-1:0] bubble_mask;
    logic [STAGES-1:0] issue_mask;
    logic              stall_acc;
    logic              stall_any;

    logic              pend_valid;
    logic              hold_active;
    logic              req_ok;
    logic              cand_valid;
    logic [SW-1:0]     cand_stage;
    logic              cand_frozen;
    logic              issue;
    logic              pend_n;
    logic              hold_n;

    logic [WDOG_W-1:0] wdog_cnt, wdog_cnt_n;

    // -----------------------------------------------------------------------
    // Freeze and bubble masks: a stall at stage j freezes every younger stage
    // (indices <= j); a bubble goes into the first stage that keeps moving
    // behind a frozen one.
    // -----------------------------------------------------------------------
    always_comb begin
        stall_mask = '0;
        stall_acc  = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stall_acc     = stall_acc | stall_req[k];
            stall_mask[k] = stall_acc;
        end
    end

    always_comb begin
        bubble_mask = '0;
        for (int k = 1; k < STAGES; k++) begin
            bubble_mask[k] = stall_mask[k-1] & ~stall_mask[k];
        end
    end

    assign stall_any = |stall_mask;

    // -----------------------------------------------------------------------
    // Flush candidate selection
    // -----------------------------------------------------------------------
    assign pend_valid  = (state == ST_PEND) || (state == ST_PEND_HOLD);
    assign hold_active = (state == ST_HOLD) || (state == ST_PEND_HOLD);

    // Stage 0 has no older stage to flush from, and out-of-range indices
    // name no stage at all, so such requests are dropped outright.
    assign req_ok = flush_req && (flush_stage != '0) && ({1'b0, flush_stage} < STAGES_W);

    always_comb begin
        cand_stage = pend_stage;
        if (req_ok && pend_valid) begin
            // Larger index = older instruction; its flush covers the other.
            cand_stage = (flush_stage > pend_stage) ? flush_stage : pend_stage;
        end else if (req_ok) begin
            cand_stage = flush_stage;
        end
    end

    assign cand_valid = req_ok || pend_valid;

    always_comb begin
        cand_frozen = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (cand_stage == SW'(k)) begin
                cand_frozen = stall_mask[k];
            end
        end
    end

    assign issue = cand_valid && !cand_frozen;

    // Invalidate every stage younger than the source, never the PC stage.
    always_comb begin
        issue_mask = '0;
        for (int k = 1; k < STAGES; k++) begin
            issue_mask[k] = issue && (SW'(k) < cand_stage);
        end
    end

    // -----------------------------------------------------------------------
    // Flush FSM
    // -----------------------------------------------------------------------
    always_comb begin
        pend_n       = cand_valid && !issue;
        pend_stage_n = pend_n ? cand_stage : '0;
        hold_n       = 1'b0;
        hold_cnt_n   = '0;
        hold_mask_n  = '0;

        if (issue) begin
            // A new issue merges into whatever is still being held and
            // restarts the hold window.
            hold_n      = HOLD_ON_ISSUE;
            hold_cnt_n  = HOLD_LOAD;
            hold_mask_n = issue_mask | (hold_active ? hold_mask : '0);
        end else if (hold_active) begin
            hold_cnt_n  = hold_cnt - HW'(1);
            hold_n      = (hold_cnt != HW'(1));
            hold_mask_n = hold_n ? hold_mask : '0;
        end

        if (!hold_n) begin
            hold_cnt_n = '0;
        end

        case ({hold_n, pend_n})
            2'b01:   state_n = ST_PEND;
            2'b10:   state_n = ST_HOLD;
            2'b11:   state_n = ST_PEND_HOLD;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend_stage <= '0;
            hold_cnt   <= '0;
            hold_mask  <= '0;
        end else begin
            state      <= state_n;
            pend_stage <= pend_stage_n;
            hold_cnt   <= hold_cnt_n;
            hold_mask  <= hold_mask_n;
        end
    end

    // -----------------------------------------------------------------------
    // Watchdog and performance counters
    // -----------------------------------------------------------------------
    always_comb begin
        wdog_cnt_n = '0;
        if (stall_any) begin
            wdog_cnt_n = (wdog_cnt == WDOG_MAX) ? wdog_cnt : wdog_cnt + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            wdog_cnt <= wdog_cnt_n;
            if (wdog_cnt_n == WDOG_MAX) begin
                wdog_timeout <= 1'b1;
            end

            if (perf_clr) begin
                stall_cycles <= '0;
                flush_count  <= '0;
            end else begin
                if (stall_any && (stall_cycles != CNT_MAX)) begin
                    stall_cycles <= stall_cycles + CNT_W'(1);
                end
                if (issue && (flush_count != CNT_MAX)) begin
                    flush_count <= flush_count + CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs; the stage-register controls are forced quiet while in reset.
    // -----------------------------------------------------------------------
    assign stall_out     = rst ? stall_mask  : '0;
    assign bubble_out    = rst ? bubble_mask : '0;
    assign flush_out     = rst ? (issue_mask | (hold_active ? hold_mask : '0)) : '0;
    assign flush_pending = pend_valid;

endmodule
